// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake on both sides.
// Single-cycle base ops plus iterative shift-add multiply and restoring divide.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [5:0]       flags
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_XOR  = 5'h04;
    localparam logic [4:0] OP_NOR  = 5'h05;
    localparam logic [4:0] OP_NOT  = 5'h06;
    localparam logic [4:0] OP_SLL  = 5'h07;
    localparam logic [4:0] OP_SRL  = 5'h08;
    localparam logic [4:0] OP_SRA  = 5'h09;
    localparam logic [4:0] OP_INC  = 5'h0A;
    localparam logic [4:0] OP_DEC  = 5'h0B;
    localparam logic [4:0] OP_SLTU = 5'h0C;
    localparam logic [4:0] OP_SGTU = 5'h0D;
    localparam logic [4:0] OP_LUI  = 5'h0E;
    localparam logic [4:0] OP_ANDN = 5'h0F;
    localparam logic [4:0] OP_SLT  = 5'h14;

    logic [1:0]       state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;
    logic             want_hi;

    logic             accept;
    logic             multi;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             ill;

    logic [WIDTH:0]   psum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   rdiff;
    logic             ge;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic [WIDTH-1:0] fin;
    logic             dz_n;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign multi    = (op[4:2] == 3'b100);
    assign sh       = b[SHW-1:0];

    always_comb begin
        sum = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = a - b;
                c   = a < b;
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_NOT:  res = ~a;
            OP_SLL:  res = a << sh;
            OP_SRL:  res = a >> sh;
            OP_SRA:  res = $signed(a) >>> sh;
            OP_INC: begin
                sum = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = !a[WIDTH-1] && res[WIDTH-1];
            end
            OP_DEC: begin
                res = a - {{(WIDTH-1){1'b0}}, 1'b1};
                c   = (a == '0);
                v   = a[WIDTH-1] && !res[WIDTH-1];
            end
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SGTU: res = {{(WIDTH-1){1'b0}}, a > b};
            OP_LUI:  res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_ANDN: res = a & ~b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: ill = 1'b1;
        endcase
    end

    // hi:lo is the product register for MUL and remainder:quotient for DIV
    always_comb begin
        psum  = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {WIDTH{1'b0}})};
        rsh   = {hi, lo[WIDTH-1]};
        ge    = rsh >= {1'b0, mcand};
        rdiff = rsh - {1'b0, mcand};
        if (state == MUL) begin
            hi_n = psum[WIDTH:1];
            lo_n = {psum[0], lo[WIDTH-1:1]};
        end else begin
            hi_n = ge ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ge};
        end
        fin  = want_hi ? hi_n : lo_n;
        dz_n = (state == DIV) && (mcand == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            want_hi   <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && multi) begin
                        state   <= op[1] ? DIV : MUL;
                        cnt     <= '0;
                        want_hi <= op[0];
                        mcand   <= op[1] ? b : a;
                        hi      <= '0;
                        lo      <= op[1] ? a : b;
                    end else if (accept) begin
                        result    <= res;
                        flags     <= {ill, 1'b0, v, c, res[WIDTH-1], res == '0};
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        result    <= fin;
                        flags     <= {1'b0, dz_n, 2'b00, fin[WIDTH-1], fin == '0};
                        out_valid <= 1'b1;
                        state     <= IDLE;
                        cnt       <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: random and directed ops against an
// arithmetic reference model, with output back-pressure and reset abort.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   req_op = '0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [5:0]   flags;

    int total = 0;
    int bad = 0;
    int ready_mode = 1;
    logic [37:0] exp_q[$];
    logic [37:0] mon_exp;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(req_op),
        .a(req_a),
        .b(req_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .flags(flags)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the op definitions
    function automatic logic [37:0] model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic c, v, dz, il;
        longint sx, sy, s;
        logic [63:0] p;
        int sh;
        sx = $signed(x);
        sy = $signed(y);
        sh = int'(y % 32);
        p = {32'b0, x} * {32'b0, y};
        c = 0; v = 0; dz = 0; il = 0; s = 0;
        case (o)
            5'h00: begin s = sx + sy; r = s[31:0]; c = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF; v = s != longint'($signed(r)); end
            5'h01: begin s = sx - sy; r = s[31:0]; c = x < y; v = s != longint'($signed(r)); end
            5'h02: r = x & y;
            5'h03: r = x | y;
            5'h04: r = x ^ y;
            5'h05: r = ~(x | y);
            5'h06: r = ~x;
            5'h07: r = x << sh;
            5'h08: r = x >> sh;
            5'h09: begin s = sx >>> sh; r = s[31:0]; end
            5'h0A: begin s = sx + 1; r = s[31:0]; c = (x == 32'hFFFF_FFFF); v = s != longint'($signed(r)); end
            5'h0B: begin s = sx - 1; r = s[31:0]; c = (x < 1); v = s != longint'($signed(r)); end
            5'h0C: r = (x < y) ? 1 : 0;
            5'h0D: r = (x > y) ? 1 : 0;
            5'h0E: r = (y % 65536) * 65536;
            5'h0F: r = x & ~y;
            5'h10: r = p[31:0];
            5'h11: r = p[63:32];
            5'h12: begin dz = (y == 0); r = dz ? 32'hFFFF_FFFF : x / y; end
            5'h13: begin dz = (y == 0); r = dz ? x : x % y; end
            5'h14: r = (sx < sy) ? 1 : 0;
            default: begin r = 0; il = 1; end
        endcase
        return {il, dz, v, c, r[31], r == 0, r};
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = ($urandom_range(0, 3) != 0);
            1: out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out got=%h exp=none", {flags, result});
            end else begin
                mon_exp = exp_q.pop_front();
                chk("scoreboard", {flags, result}, mon_exp);
            end
        end
    end

    task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output bit ok);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        req_op = o;
        req_a = x;
        req_b = y;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL accept_timeout got=busy exp=ready");
            in_valid = 1'b0;
            ok = 0;
            return;
        end
        exp_q.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        req_a = $urandom;
        req_b = $urandom;
        req_op = 5'($urandom);
        ok = 1;
    endtask

    task automatic run1(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic [5:0] ef, input int lat, input string name);
        bit ok;
        int n = 0;
        int busy = 0;
        issue(o, x, y, ok);
        if (!ok) return;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            if (!in_ready) busy++;
            n++;
            @(negedge clk);
        end
        chk({name, "_res"}, result, er);
        chk({name, "_flags"}, flags, ef);
        chk({name, "_lat"}, n, lat);
        chk({name, "_busy"}, busy, lat);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit ok;
        logic [W-1:0] r0;
        logic [5:0] f0;
        int stale;

        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        run1(5'h00, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 6'b001010, 0, "add_ovf");
        run1(5'h01, 32'h0, 32'h1, 32'hFFFF_FFFF, 6'b000110, 0, "sub_borrow");
        run1(5'h09, 32'h8000_0000, 32'h4, 32'hF800_0000, 6'b000010, 0, "sra");
        run1(5'h14, 32'hFFFF_FFFF, 32'h1, 32'h1, 6'b000000, 0, "slt");
        run1(5'h0C, 32'hFFFF_FFFF, 32'h1, 32'h0, 6'b000001, 0, "sltu");
        run1(5'h0E, 32'h0, 32'h1234_ABCD, 32'hABCD_0000, 6'b000010, 0, "lui");
        run1(5'h15, 32'h3, 32'h4, 32'h0, 6'b100001, 0, "illegal");
        run1(5'h10, 32'h0001_0000, 32'h0001_0000, 32'h0, 6'b000001, W, "mul");
        run1(5'h11, 32'h0001_0000, 32'h0001_0000, 32'h1, 6'b000000, W, "mulh");
        run1(5'h12, 32'd100, 32'd7, 32'd14, 6'b000000, W, "divu");
        run1(5'h13, 32'd100, 32'd7, 32'd2, 6'b000000, W, "remu");
        run1(5'h12, 32'd5, 32'd0, 32'hFFFF_FFFF, 6'b010010, W, "divu_dz");
        run1(5'h13, 32'd5, 32'd0, 32'd5, 6'b010000, W, "remu_dz");
        drain();

        // Output stall: result must hold and nothing new may be accepted
        ready_mode = 2;
        issue(5'h00, 32'd40, 32'd2, ok);
        @(negedge clk);
        chk("stall_valid0", out_valid, 1);
        r0 = result;
        f0 = flags;
        in_valid = 1'b1;
        req_op = 5'h04;
        req_a = 32'hF0F0_1234;
        req_b = 32'h0FF0_0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_res", result, r0);
            chk("stall_flags", flags, f0);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        ready_mode = 1;
        issue(5'h04, 32'hF0F0_1234, 32'h0FF0_0001, ok);
        drain();

        for (int i = 0; i < 250; i++) begin
            ready_mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
            issue(5'($urandom_range(0, 31)), rnd_val(), rnd_val(), ok);
            if ($urandom_range(0, 7) == 0) @(negedge clk);
        end
        ready_mode = 1;
        drain();

        // Reset in the middle of a divide discards it
        issue(5'h12, 32'd1000, 32'd3, ok);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run1(5'h00, 32'd2, 32'd3, 32'd5, 6'b000000, 0, "add_after_rst");
        @(negedge clk);
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale", stale, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
